// File: rtl/scurve_channel_sequencer_pkg.sv
// Shared definitions for the S-curve sweep logic: FSM encoding, record framing
// words and the DAC bit-reverse mapping used by the slow-control interface.
package scurve_channel_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_HEADER,
      ST_LOAD_SC,
      ST_WAIT_LOAD,
      ST_INJECT,
      ST_OUT_ID,
      ST_OUT_COUNT,
      ST_NEXT_POINT,
      ST_TAIL,
      ST_DONE
   } state_t;

   localparam logic [15:0] HEADER_WORD_DEF = 16'h5343;
   localparam logic [15:0] TAIL_WORD_DEF   = 16'h4443;
   localparam int          DAC_W           = 10;
   localparam int          CH_W            = 6;
   localparam int          CNT_W           = 16;

   // The ASIC slow-control chain shifts the DAC MSB-last, so the code is mirrored.
   function automatic logic [DAC_W-1:0] bit_reverse_dac(input logic [DAC_W-1:0] dac);
      logic [DAC_W-1:0] rev;
      for (int i = 0; i < DAC_W; i++) begin
         rev[i] = dac[DAC_W-1-i];
      end
      return rev;
   endfunction

endpackage

// File: rtl/scurve_channel_sequencer_ctest.sv
// Charge-injection pulse generator: after i_start, one pulse every PULSE_INTERVAL
// cycles starting one cycle later; o_done marks expiry of the final interval.
module scurve_channel_sequencer_ctest #(
   parameter int PULSE_INTERVAL = 2000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_abort,
   input  logic [15:0] i_pulse_num,
   output logic        o_pulse,
   output logic        o_done
);

   localparam int                TICK_W    = $clog2(PULSE_INTERVAL + 1);
   localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(PULSE_INTERVAL);

   logic              r_active;
   logic [TICK_W-1:0] r_tick;
   logic [15:0]       r_left;
   logic              w_expire;

   // Tick 0 is the entry cycle, tick 1 carries the pulse, tick PULSE_INTERVAL ends the interval.
   assign w_expire = r_active && (r_tick == TICK_LAST);
   assign o_pulse  = r_active && (r_tick == TICK_ONE);
   assign o_done   = w_expire && (r_left == 16'd1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_active <= 1'b0;
         r_tick   <= '0;
         r_left   <= '0;
      end else if (i_abort) begin
         r_active <= 1'b0;
         r_tick   <= '0;
         r_left   <= '0;
      end else if (i_start) begin
         r_active <= 1'b1;
         r_tick   <= '0;
         r_left   <= i_pulse_num;
      end else if (w_expire) begin
         if (r_left == 16'd1) begin
            r_active <= 1'b0;
            r_tick   <= '0;
            r_left   <= '0;
         end else begin
            r_tick <= TICK_ONE;
            r_left <= r_left - 16'd1;
         end
      end else if (r_active) begin
         r_tick <= r_tick + TICK_ONE;
      end
   end

endmodule

// File: rtl/scurve_channel_sequencer.sv
// S-curve sweep sequencer: walks a channel x DAC0 grid, injects test pulses,
// counts triggers per point and streams a framed record to a downstream FIFO.
module scurve_channel_sequencer
   import scurve_channel_sequencer_pkg::*;
#(
   parameter int          PULSE_INTERVAL = 2000,
   parameter logic [15:0] HEADER_WORD    = HEADER_WORD_DEF,
   parameter logic [15:0] TAIL_WORD      = TAIL_WORD_DEF
) (
   input  logic             Clk,
   input  logic             reset_n,
   input  logic             SweepStart,
   input  logic             SweepStop,
   input  logic [CH_W-1:0]  StartChannel,
   input  logic [CH_W-1:0]  EndChannel,
   input  logic [DAC_W-1:0] StartDAC0,
   input  logic [DAC_W-1:0] StopDAC0,
   input  logic [15:0]      TestPulseNumber,
   input  logic             TriggerIn,
   input  logic             SCLoadDone,
   input  logic             FifoFull,
   output logic [DAC_W-1:0] OutDAC0,
   output logic [CH_W-1:0]  MaskChannel,
   output logic             LoadSCParameter,
   output logic             CTestPulse,
   output logic [15:0]      SweepData,
   output logic             SweepData_en,
   output logic             SweepBusy,
   output logic             SweepDone
);

   state_t             r_state;
   state_t             w_next;
   logic [CH_W-1:0]    r_start_ch;
   logic [CH_W-1:0]    r_end_ch;
   logic [DAC_W-1:0]   r_start_dac;
   logic [DAC_W-1:0]   r_stop_dac;
   logic [15:0]        r_pulse_num;
   logic [CH_W-1:0]    r_ch;
   logic [DAC_W-1:0]   r_dac;
   logic [CNT_W-1:0]   r_trig_cnt;
   logic [15:0]        w_word;
   logic               w_wr_req;
   logic               w_abort;
   logic               w_empty;
   logic               w_gen_start;
   logic               w_inject_done;

   assign w_empty     = (r_start_ch > r_end_ch) || (r_start_dac > r_stop_dac);
   assign w_gen_start = (r_state == ST_WAIT_LOAD) && SCLoadDone && (r_pulse_num != 16'd0);

   scurve_channel_sequencer_ctest #(
      .PULSE_INTERVAL (PULSE_INTERVAL)
   ) u_ctest (
      .i_clk       (Clk),
      .i_rst_n     (reset_n),
      .i_start     (w_gen_start),
      .i_abort     (w_abort),
      .i_pulse_num (r_pulse_num),
      .o_pulse     (CTestPulse),
      .o_done      (w_inject_done)
   );

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      w_word   = '0;
      w_wr_req = 1'b0;
      w_abort  = 1'b0;
      case (r_state)
         ST_IDLE:       if (SweepStart) w_next = ST_HEADER;
         ST_HEADER: begin
            w_word   = HEADER_WORD;
            w_wr_req = 1'b1;
            if (!FifoFull) w_next = w_empty ? ST_TAIL : ST_LOAD_SC;
         end
         ST_LOAD_SC:    w_next = ST_WAIT_LOAD;
         ST_WAIT_LOAD:  if (SCLoadDone) w_next = (r_pulse_num == 16'd0) ? ST_OUT_ID : ST_INJECT;
         ST_INJECT:     if (w_inject_done) w_next = ST_OUT_ID;
         ST_OUT_ID: begin
            w_word   = {r_ch, r_dac};
            w_wr_req = 1'b1;
            if (!FifoFull) w_next = ST_OUT_COUNT;
         end
         ST_OUT_COUNT: begin
            w_word   = r_trig_cnt;
            w_wr_req = 1'b1;
            if (!FifoFull) w_next = ST_NEXT_POINT;
         end
         ST_NEXT_POINT: w_next = ((r_dac != r_stop_dac) || (r_ch != r_end_ch)) ? ST_LOAD_SC : ST_TAIL;
         ST_TAIL: begin
            w_word   = TAIL_WORD;
            w_wr_req = 1'b1;
            if (!FifoFull) w_next = ST_DONE;
         end
         ST_DONE:       w_next = ST_IDLE;
         default:       w_next = ST_IDLE;
      endcase
      // A word being written this cycle still goes out; only the transition is redirected.
      if (SweepStop && !(r_state inside {ST_IDLE, ST_TAIL, ST_DONE})) begin
         w_abort = 1'b1;
         w_next  = ST_TAIL;
      end
   end

   always_ff @(posedge Clk or negedge reset_n) begin
      if (!reset_n) begin
         r_start_ch  <= '0;
         r_end_ch    <= '0;
         r_start_dac <= '0;
         r_stop_dac  <= '0;
         r_pulse_num <= '0;
         r_ch        <= '0;
         r_dac       <= '0;
         r_trig_cnt  <= '0;
      end else begin
         if ((r_state == ST_IDLE) && SweepStart) begin
            r_start_ch  <= StartChannel;
            r_end_ch    <= EndChannel;
            r_start_dac <= StartDAC0;
            r_stop_dac  <= StopDAC0;
            r_pulse_num <= TestPulseNumber;
            r_ch        <= StartChannel;
            r_dac       <= StartDAC0;
         end
         if (r_state == ST_WAIT_LOAD) begin
            r_trig_cnt <= '0;
         end else if ((r_state == ST_INJECT) && TriggerIn && (r_trig_cnt != '1)) begin
            r_trig_cnt <= r_trig_cnt + CNT_W'(1);
         end
         // Equality compares against the end points keep 1023/63 from ever incrementing.
         if ((r_state == ST_NEXT_POINT) && !SweepStop) begin
            if (r_dac != r_stop_dac) begin
               r_dac <= r_dac + DAC_W'(1);
            end else if (r_ch != r_end_ch) begin
               r_ch  <= r_ch + CH_W'(1);
               r_dac <= r_start_dac;
            end
         end
      end
   end

   assign OutDAC0         = bit_reverse_dac(r_dac);
   assign MaskChannel     = r_ch;
   assign LoadSCParameter = (r_state == ST_LOAD_SC);
   assign SweepData       = w_word;
   assign SweepData_en    = w_wr_req && !FifoFull;
   assign SweepBusy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign SweepDone       = (r_state == ST_DONE);

endmodule

// File: tb/tb_scurve_channel_sequencer.sv
// Randomised bench for the S-curve sequencer with a record-level reference model:
// expected words, pulse timing and trigger counts derived from the sweep rules.
module tb_scurve_channel_sequencer;

   localparam int P = 20;

   logic        Clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        SweepStart = 1'b0;
   logic        SweepStop = 1'b0;
   logic [5:0]  StartChannel = '0;
   logic [5:0]  EndChannel = '0;
   logic [9:0]  StartDAC0 = '0;
   logic [9:0]  StopDAC0 = '0;
   logic [15:0] TestPulseNumber = '0;
   logic        TriggerIn = 1'b0;
   logic        SCLoadDone = 1'b0;
   logic        FifoFull = 1'b0;
   logic [9:0]  OutDAC0;
   logic [5:0]  MaskChannel;
   logic        LoadSCParameter;
   logic        CTestPulse;
   logic [15:0] SweepData;
   logic        SweepData_en;
   logic        SweepBusy;
   logic        SweepDone;

   scurve_channel_sequencer #(.PULSE_INTERVAL(P)) dut (
      .Clk(Clk), .reset_n(reset_n), .SweepStart(SweepStart), .SweepStop(SweepStop),
      .StartChannel(StartChannel), .EndChannel(EndChannel), .StartDAC0(StartDAC0),
      .StopDAC0(StopDAC0), .TestPulseNumber(TestPulseNumber), .TriggerIn(TriggerIn),
      .SCLoadDone(SCLoadDone), .FifoFull(FifoFull), .OutDAC0(OutDAC0),
      .MaskChannel(MaskChannel), .LoadSCParameter(LoadSCParameter), .CTestPulse(CTestPulse),
      .SweepData(SweepData), .SweepData_en(SweepData_en), .SweepBusy(SweepBusy),
      .SweepDone(SweepDone)
   );

   always #5 Clk = ~Clk;

   int          total = 0;
   int          bad = 0;
   longint      cyc = 0;
   logic [15:0] expq[$];
   logic [15:0] got[$];
   longint      pb = 0;
   longint      pe = 0;
   int          pn = 0;
   int          ld_cnt = 0;
   bit          full_force = 1'b0;
   int          full_mode = 0;

   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic summary();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   task automatic timeout(input string name);
      total++;
      bad++;
      $display("FAIL %s: event not seen within cycle budget (cycle %0d)", name, cyc);
      summary();
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [9:0] rev10(input logic [9:0] v);
      logic [9:0] r;
      for (int i = 0; i < 10; i++) r[9-i] = v[i];
      return r;
   endfunction

   task automatic chk_reset_outputs();
      check("rst_OutDAC0", OutDAC0, 0);
      check("rst_MaskChannel", MaskChannel, 0);
      check("rst_LoadSCParameter", LoadSCParameter, 0);
      check("rst_CTestPulse", CTestPulse, 0);
      check("rst_SweepData", SweepData, 0);
      check("rst_SweepData_en", SweepData_en, 0);
      check("rst_SweepBusy", SweepBusy, 0);
      check("rst_SweepDone", SweepDone, 0);
   endtask

   // Downstream FIFO model: random or forced backpressure.
   initial forever begin
      @(posedge Clk);
      #2;
      FifoFull = full_force | ((full_mode == 1) && ($urandom_range(3) == 0));
   end

   // Compare process: pulse timing, record words and load requests every cycle.
   always @(negedge Clk) begin
      if (reset_n) begin
         longint d;
         logic   exp_ctp;
         d = cyc - pb;
         exp_ctp = (pn > 0) && (d >= 0) && (cyc <= pe) && ((d % P) == 0) && ((d / P) < pn);
         check("ctest_pulse", CTestPulse, exp_ctp);
         if (LoadSCParameter) ld_cnt++;
         if (SweepData_en) begin
            check("strobe_while_full", FifoFull, 0);
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: got %h, expected no write (cycle %0d)", SweepData, cyc);
            end else begin
               check("sweep_word", SweepData, expq.pop_front());
            end
            got.push_back(SweepData);
         end
      end
   end

   // trig_mode: 0 random, 1 exactly three triggers per point, 2 held high.
   task automatic run_sweep(input int sc, input int ec, input int sd, input int ed, input int n,
                            input int trig_mode, input int stop_point, input int event_at,
                            input int reset_point, input int fifo_point);
      int          ld0;
      int          pt;
      bit          ok;
      bit          aborted;
      bit          rst_hit;
      logic [15:0] cnt;
      ld0 = ld_cnt;
      pt = 0;
      aborted = 0;
      rst_hit = 0;
      expq.push_back(16'h5343);
      tick();
      StartChannel = 6'(sc); EndChannel = 6'(ec);
      StartDAC0 = 10'(sd); StopDAC0 = 10'(ed); TestPulseNumber = 16'(n);
      SweepStart = 1'b1;
      tick();
      SweepStart = 1'b0;
      StartChannel = 6'($urandom); EndChannel = 6'($urandom);
      StartDAC0 = 10'($urandom); StopDAC0 = 10'($urandom); TestPulseNumber = 16'($urandom);
      @(negedge Clk);
      check("busy_after_start", SweepBusy, 1);
      for (int ch = sc; ch <= ec && !aborted; ch++) begin
         for (int dac = sd; dac <= ed && !aborted; dac++) begin
            ok = 0;
            for (int w = 0; w < 400; w++) begin
               @(negedge Clk);
               TriggerIn = ($urandom_range(1) == 1);
               if (LoadSCParameter) begin ok = 1; break; end
            end
            if (!ok) timeout("load_sc_request");
            pt++;
            check("mask_channel", MaskChannel, ch);
            check("out_dac0", OutDAC0, rev10(10'(dac)));
            repeat ($urandom_range(3)) begin tick(); TriggerIn = ($urandom_range(1) == 1); end
            tick();
            SCLoadDone = 1'b1;
            TriggerIn = ($urandom_range(1) == 1);
            cnt = 0;
            pb = cyc + 2;
            pe = 64'h7fff_ffff_ffff;
            pn = n;
            for (int i = 0; i < n * P + 1 && n > 0; i++) begin
               tick();
               SCLoadDone = 1'b0;
               case (trig_mode)
                  1:       TriggerIn = (i == 5 || i == 7 || i == 9);
                  2:       TriggerIn = 1'b1;
                  default: TriggerIn = ($urandom_range(2) == 0);
               endcase
               if (pt - 1 == stop_point && i == event_at) begin
                  SweepStop = 1'b1;
                  pe = cyc;
                  aborted = 1;
                  break;
               end
               if (pt - 1 == reset_point && i == event_at) begin
                  pn = 0;
                  reset_n = 1'b0;
                  TriggerIn = 1'b0;
                  #1;
                  chk_reset_outputs();
                  repeat (3) tick();
                  reset_n = 1'b1;
                  expq.delete();
                  repeat (20) @(negedge Clk);
                  check("idle_after_reset", SweepBusy, 0);
                  rst_hit = 1;
                  aborted = 1;
                  break;
               end
               if (TriggerIn && cnt != 16'hFFFF) cnt++;
            end
            if (!aborted) begin
               tick();
               SCLoadDone = 1'b0;
               TriggerIn = ($urandom_range(1) == 1);
               expq.push_back(16'((ch << 10) | dac));
               expq.push_back(cnt);
               if (pt - 1 == fifo_point) begin
                  tick();
                  full_force = 1'b1;
                  for (int k = 0; k < 50; k++) begin
                     @(negedge Clk);
                     check("no_strobe_while_full", SweepData_en, 0);
                  end
                  check("data_held_while_full", SweepData, cnt);
                  tick();
                  full_force = 1'b0;
               end
            end
         end
      end
      if (rst_hit) return;
      if (SweepStop) begin
         tick();
         SweepStop = 1'b0;
      end
      expq.push_back(16'h4443);
      ok = 0;
      for (int w = 0; w < 400; w++) begin
         @(negedge Clk);
         if (SweepDone) begin ok = 1; break; end
      end
      if (!ok) timeout("sweep_done");
      check("busy_at_done", SweepBusy, 0);
      check("record_complete", expq.size(), 0);
      check("load_sc_pulses", ld_cnt - ld0, pt);
   endtask

   initial begin
      int g0;
      int sc;
      int ec;
      int sd;
      int ed;
      logic [15:0] lit[8];
      repeat (2) @(negedge Clk);
      chk_reset_outputs();
      tick();
      reset_n = 1'b1;

      // Directed single-channel sweep with three triggers per point.
      g0 = got.size();
      run_sweep(5, 5, 100, 102, 10, 1, -1, 0, -1, -1);
      lit = '{16'h5343, 16'h1464, 16'h0003, 16'h1465, 16'h0003, 16'h1466, 16'h0003, 16'h4443};
      check("directed_len", got.size() - g0, 8);
      for (int k = 0; k < 8; k++) check("directed_word", got[g0 + k], lit[k]);

      // Empty DAC range: header and tail only.
      g0 = got.size();
      run_sweep(0, 0, 200, 100, 10, 0, -1, 0, -1, -1);
      check("empty_len", got.size() - g0, 2);
      check("empty_hdr", got[g0], 16'h5343);
      check("empty_tail", got[g0 + 1], 16'h4443);

      // Top corner of the grid with random backpressure.
      full_mode = 1;
      g0 = got.size();
      run_sweep(62, 63, 1022, 1023, 1, 0, -1, 0, -1, -1);
      check("corner_len", got.size() - g0, 10);
      check("corner_id0", got[g0 + 1], 16'hFBFE);
      check("corner_id1", got[g0 + 3], 16'hFBFF);
      check("corner_id2", got[g0 + 5], 16'hFFFE);
      check("corner_id3", got[g0 + 7], 16'hFFFF);

      for (int k = 0; k < 4; k++) begin
         sc = $urandom_range(63);
         ec = (sc == 63) ? 63 : sc + $urandom_range(1);
         sd = $urandom_range(1023);
         ed = (sd + 2 > 1023) ? 1023 : sd + $urandom_range(2);
         run_sweep(sc, ec, sd, ed, $urandom_range(3), 0, -1, 0, -1, -1);
      end
      full_mode = 0;

      run_sweep(7, 7, 300, 300, 2, 0, -1, 0, -1, 0);
      run_sweep(3, 3, 10, 11, 4, 0, 1, 40, -1, -1);
      run_sweep(1, 2, 5, 6, 3, 0, -1, 10, 0, -1);
      run_sweep(20, 21, 500, 501, 2, 0, -1, 0, -1, -1);

      g0 = got.size();
      run_sweep(9, 9, 0, 0, 3280, 2, -1, 0, -1, -1);
      check("saturated_count", got[g0 + 2], 16'hFFFF);

      summary();
   end

   initial begin
      #2000000;
      timeout("global_watchdog");
   end

endmodule
